hex_result_uart_tx: RTL and testbench
=====================================

HEX_RESULT_UART_TX -- requirements
Module: hex_result_uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50_000_000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate in bits/s.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to send the current data.
REQ-006 SHALL have port data, input, 16 bits: calculator result to print.
REQ-007 SHALL have port overflow, input, 1 bit: when high, the result is invalid.
REQ-008 SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: high while a message is in flight.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at message completion.

Function
REQ-011 SHALL define CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division); every transmitted bit SHALL last exactly CYCLES_PER_BIT cycles.
REQ-012 SHALL accept start only when busy=0; start while busy=1 SHALL be ignored (no queueing, no latching).
REQ-013 SHALL sample data and overflow in the acceptance cycle; later input changes SHALL NOT affect the message.
REQ-014 SHALL send a 6-character message per accepted start.
- overflow=0: hex digits data[15:12], [11:8], [7:4], [3:0], then CR (0x0D), LF (0x0A).
- overflow=1: 'O' (0x4F), 'V' (0x56), 'F' (0x46), '!' (0x21), CR, LF.
REQ-015 SHALL encode hex nibbles 0-9 as 0x30-0x39 and A-F as uppercase 0x41-0x46.
REQ-016 SHALL frame each character 8N1, with no idle gap between characters:
- start bit 0;
- 8 data bits, LSB first;
- 1 stop bit 1.
REQ-017 SHALL implement FSM states IDLE, START_BIT, DATA_BITS, STOP_BIT:
- IDLE->START_BIT on accepted start;
- START_BIT->DATA_BITS after 1 bit time;
- DATA_BITS->STOP_BIT after 8 bit times;
- STOP_BIT->START_BIT if characters remain, else ->IDLE.
REQ-018 Timing for start accepted in cycle N:
- tx=0 and busy=1 from cycle N+1;
- message occupies cycles N+1..N+60*CYCLES_PER_BIT;
- in cycle N+60*CYCLES_PER_BIT+1, busy=0 and done=1 for exactly one cycle.
REQ-019 SHALL accept a start in the same cycle that done=1 (back-to-back messages, minimum 0 idle bits between stop and next start bit).
REQ-020 tx SHALL be driven from a register (glitch-free), and SHALL be 1 in IDLE.
REQ-021 busy SHALL equal (state != IDLE); done SHALL never be asserted while busy=1.
REQ-022 Counters SHALL be sized for the parameters:
- bit-time counter: $clog2(CYCLES_PER_BIT) bits;
- bit index: 0..7;
- character index: 0..5.
None SHALL wrap mid-message.

Reset
REQ-023 Reset outputs SHALL be: tx=1, busy=0, done=0; the FSM SHALL be in IDLE with all counters cleared.
REQ-024 Reset asserted mid-message SHALL abort it with tx=1 on the next cycle, SHALL produce no done pulse, and SHALL leave no residual character.
REQ-025 start asserted together with reset SHALL be ignored.

Verification (CLOCK_FREQUENCY=1_000_000, BAUD_RATE=100_000, so CYCLES_PER_BIT=10)
REQ-026 start at cycle N, data=0x12AF, overflow=0 -> bytes decoded 0x31, 0x32, 0x41, 0x46, 0x0D, 0x0A; each bit 10 cycles; busy N+1..N+600; done=1 only at N+601.
REQ-027 start, data=0xFFFF, overflow=1 -> bytes 0x4F, 0x56, 0x46, 0x21, 0x0D, 0x0A.
REQ-028 start, data=0x0000; data changed to 0x9999 at N+5; second start at N+50 -> bytes 0x30 x4, 0x0D, 0x0A only; exactly one done pulse.
REQ-029 start asserted again in the done cycle with data=0xBEEF -> next start bit begins at N+602; second message 0x42, 0x45, 0x45, 0x46, 0x0D, 0x0A.
REQ-030 reset at N+250 (mid third character) -> tx=1, busy=0 from N+251; no done; a subsequent start produces a complete, correct message.
REQ-031 A scoreboard SHALL sample tx at mid-bit and flag:
- any start bit not 0 or stop bit not 1;
- any character count other than 6 per done.

Source files
------------

// File: rtl/hex_result_uart_tx.sv
// Prints a 16-bit result as four hex digits plus CR/LF over an 8N1 UART,
// or "OVF!" plus CR/LF when the result overflowed.
module hex_result_uart_tx #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data,
  input  logic        overflow,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W =
    (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CYCLES_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       chr_q, chr_d;
  logic [15:0]      msg_q, msg_d;
  logic             ovf_q, ovf_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic [7:0]       cur_char;
  logic             bit_tick;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n})
                       : (8'h37 + {4'h0, n});
  endfunction

  // Character for the current slot, taken from the captured message.
  always_comb begin
    cur_char = 8'h0A;
    unique case (chr_q)
      3'd0: cur_char = ovf_q ? 8'h4F : hex_ascii(msg_q[15:12]);
      3'd1: cur_char = ovf_q ? 8'h56 : hex_ascii(msg_q[11:8]);
      3'd2: cur_char = ovf_q ? 8'h46 : hex_ascii(msg_q[7:4]);
      3'd3: cur_char = ovf_q ? 8'h21 : hex_ascii(msg_q[3:0]);
      3'd4: cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  assign bit_tick = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    msg_d   = msg_q;
    ovf_d   = ovf_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = START_BIT;
          tx_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = 3'd0;
          chr_d   = 3'd0;
          msg_d   = data;
          ovf_d   = overflow;
        end
      end
      START_BIT: begin
        if (bit_tick) begin
          state_d = DATA_BITS;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = cur_char[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_char[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (chr_q == 3'd5) begin
            state_d = IDLE;
            chr_d   = 3'd0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            state_d = START_BIT;
            chr_d   = chr_q + 3'd1;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      chr_q   <= 3'd0;
      msg_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      msg_q   <= msg_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_hex_result_uart_tx.sv
// Randomized scoreboard bench: a UART receiver decodes tx at mid-bit
// and compares each character with a queue filled at stimulus time.
module tb_hex_result_uart_tx;

  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int CPB = CF / BR;
  localparam int MSG = 60 * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        overflow = 1'b0;
  logic        tx, busy, done;

  hex_result_uart_tx #(
    .CLOCK_FREQUENCY(CF),
    .BAUD_RATE(BR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .data(data),
    .overflow(overflow),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int rst_cnt = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) rst_cnt <= rst_cnt + 1;
  end

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int nchar = 0;
  int n_done = 0;
  int exp_done = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // Reference: message text derived straight from the print rules.
  task automatic push_expected(logic [15:0] d, logic o);
    string hx;
    string s;
    hx = "0123456789ABCDEF";
    if (o) s = "OVF!";
    else begin
      s = "";
      for (int i = 3; i >= 0; i--) begin
        int n;
        n = (d >> (4 * i)) & 15;
        s = {s, hx.substr(n, n)};
      end
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Monitor: mid-bit UART receiver plus done bookkeeping.
  int rst_seen = 0;
  bit rx_act = 1'b0;
  int off = 0;
  logic [7:0] sh = 8'h00;
  always @(negedge clock) begin
    if (rst_cnt != rst_seen) begin
      rst_seen = rst_cnt;
      rx_act = 1'b0;
      exp_q.delete();
      nchar = 0;
    end else begin
      if (!rx_act) begin
        if (tx === 1'b0) begin
          rx_act = 1'b1;
          off = 0;
        end
      end else begin
        off++;
        if (off == CPB / 2)
          chk("start_bit", tx, 0);
        else if (off >= CPB + CPB / 2 && off < 9 * CPB &&
                 (off % CPB) == CPB / 2)
          sh[(off - CPB) / CPB] = tx;
        else if (off == 9 * CPB + CPB / 2) begin
          chk("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_char: got %02h expected none", sh);
          end else begin
            chk("char", sh, exp_q.pop_front());
          end
          nchar++;
          rx_act = 1'b0;
        end
      end
      if (done === 1'b1) begin
        chk("chars_per_done", nchar, 6);
        chk("busy_with_done", busy, 0);
        nchar = 0;
        n_done++;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 2000) begin
      tick();
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic issue(logic [15:0] d, logic o, output int n);
    data = d;
    overflow = o;
    start = 1'b1;
    n = cyc;
    push_expected(d, o);
    exp_done++;
    tick();
    start = 1'b0;
  endtask

  // Checks cycle N+1 through the done cycle N+601; returns there.
  task automatic check_timing(int n);
    int viol;
    viol = 0;
    wait_cyc(n + 1);
    chk("tx_low_n1", tx, 0);
    chk("busy_n1", busy, 1);
    while (cyc <= n + MSG) begin
      if (busy !== 1'b1 || done !== 1'b0) viol++;
      tick();
    end
    chk("busy_window", viol, 0);
    chk("done_pulse", done, 1);
    chk("busy_fall", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, d0;
    logic [15:0] rd;
    logic ro;

    tick();
    tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();

    issue(16'h12AF, 1'b0, n);
    check_timing(n);
    tick();
    chk("done_one_cycle", done, 0);

    tick();
    issue(16'hFFFF, 1'b1, n);
    check_timing(n);
    tick();

    issue(16'h0000, 1'b0, n);
    d0 = n_done;
    wait_cyc(n + 5);
    data = 16'h9999;
    wait_cyc(n + 50);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_cyc(n + MSG + 1);
    chk("ignored_done", done, 1);
    wait_cyc(n + MSG + 100);
    chk("one_done", n_done - d0, 1);

    issue(16'($urandom), 1'b0, n);
    check_timing(n);
    issue(16'hBEEF, 1'b0, n2);
    chk("b2b_start_cycle", n2, n + MSG + 1);
    check_timing(n2);
    tick();

    issue(16'($urandom), 1'b0, n);
    wait_cyc(n + 250);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_done--;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    d0 = n_done;
    wait_cyc(n + 700);
    chk("abort_no_done", n_done - d0, 0);
    issue(16'($urandom), 1'b0, n);
    check_timing(n);
    tick();

    reset = 1'b1;
    start = 1'b1;
    data = 16'h5A5A;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("start_in_reset_busy", busy, 0);
    chk("start_in_reset_tx", tx, 1);
    tick();

    for (int i = 0; i < 8; i++) begin
      int gap;
      rd = 16'($urandom);
      ro = ($urandom_range(0, 3) == 0);
      issue(rd, ro, n);
      check_timing(n);
      gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 30);
      for (int g = 0; g < gap; g++) tick();
    end

    wait_idle();
    for (int g = 0; g < 20; g++) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", n_done, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
